cp_remove: RTL and testbench
============================

// Module: cp_remove
// PURPOSE
//  Sits directly downstream of Synch in the 802.16 OFDM receive chain.
//  Takes the time/frequency-corrected sample stream from Synch and strips the
//  cyclic prefix (first NCP samples) of every NFFT+NCP-sample OFDM symbol.
//  Forwards the NFFT useful samples per symbol to the FFT stage through a small
//  elastic FIFO, with Wishbone-style handshakes on both sides.
// PARAMETERS
//  NFFT     256  useful samples per OFDM symbol
//  NCP      32   cyclic-prefix samples per symbol (discarded)
//  FIFO_AW  2    FIFO address width; depth = 2**FIFO_AW (4)
// PORTS
//  CLK_I     in   1   clock, all logic on rising edge
//  RST_I     in   1   reset, asynchronous, active-low
//  DAT_I     in   32  sample from Synch {Im[31:16], Re[15:0]}, signed Q-format
//  CYC_I     in   1   frame cycle from Synch; low = between frames
//  STB_I     in   1   input sample strobe
//  ACK_O     out  1   input sample accepted
//  DAT_O     out  32  useful sample to FFT {Im, Re}
//  WE_O      out  1   write enable, equals STB_O
//  STB_O     out  1   output sample valid
//  CYC_O     out  1   output frame cycle
//  ACK_I     in   1   FFT accepts current DAT_O
//  SYM_O     out  8   index of symbol that DAT_O belongs to (wraps at 255)
// BEHAVIOUR
//  Reset (RST_I=0): ACK_O=0, STB_O=0, WE_O=0, CYC_O=0, DAT_O=0, SYM_O=0;
//   FIFO emptied; sample counter smp=0, symbol counter sym=0.
//  Input accept: acc = CYC_I & STB_I & ACK_O. ACK_O is combinational:
//   ACK_O = CYC_I & STB_I & (smp<NCP | !full). CP samples always accepted.
//  Counters (on acc): smp<NCP -> discard; else push {DAT_I, sym} into FIFO.
//   smp increments; at smp==NFFT+NCP-1 it wraps to 0 and sym increments
//   (8-bit wrap 255->0).
//  Frame boundary: CYC_I=0 in any cycle -> smp=0, sym=0 next edge; samples
//   already in FIFO are still drained; partial symbols are not padded.
//  FIFO: registered, depth 2**FIFO_AW. Push blocked when full even if a pop
//   happens in the same cycle. Simultaneous push+pop when not full/empty
//   keeps occupancy constant. No overflow, no underflow, no reordering.
//  Output: STB_O = WE_O = !empty; DAT_O/SYM_O = FIFO head. Pop on
//   STB_O & ACK_I. DAT_O/SYM_O stable while STB_O=1 & ACK_I=0.
//  Latency: sample accepted at edge n appears on DAT_O after edge n (1 cycle).
//  CYC_O: set on first push of a frame; cleared the cycle after FIFO empties
//   while CYC_I=0; stays high across symbols within a frame.
//  Throughput: 1 sample/clock sustained when ACK_I=1; output duty NFFT/(NFFT+NCP).
//  Width: data passes bit-exact, no arithmetic on samples.
// TESTING
//  1. One frame, 288 samples Re=k, Im=-k (k=0..287), ACK_I=1 -> exactly 256
//     outputs Re=32..287, Im=-32..-287, SYM_O=0, first STB_O 1 cycle after k=32 acc.
//  2. Three back-to-back symbols (864 samples) -> 768 outputs; SYM_O=0,1,2;
//     k=288..319 and 576..607 discarded; STB_O gap of 32 cycles between symbols.
//  3. ACK_I=0 for 20 cycles during useful part -> FIFO holds 4, ACK_O drops
//     after 4th push, DAT_O frozen; on ACK_I=1 all samples out in order, none lost.
//  4. CYC_I dropped after k=100 then new frame -> 68 outputs (Re=32..99) from
//     frame 1; frame 2 again discards its first 32 samples, SYM_O restarts at 0;
//     CYC_O falls once FIFO drains.
//  5. RST_I pulsed low mid-symbol with FIFO non-empty -> all outputs 0
//     immediately (async); next frame processed as in test 1.
//  6. Random STB_I/ACK_I gaps (50% each), 5 symbols -> output equals golden
//     CP-stripped stream, 1280 samples, SYM_O=0..4.

Source files
------------

// File: rtl/cp_remove_if.sv
// Bus bundle for the cyclic-prefix remover: Synch-facing input handshake and
// FFT-facing output handshake, both Wishbone-style.
interface cp_remove_if;
    logic [31:0] DAT_I;   // {Im, Re} from Synch
    logic        CYC_I;
    logic        STB_I;
    logic        ACK_O;
    logic [31:0] DAT_O;   // {Im, Re} to FFT
    logic        WE_O;
    logic        STB_O;
    logic        CYC_O;
    logic        ACK_I;
    logic [7:0]  SYM_O;

    // Block side: consumes the sample stream, produces the useful-sample stream.
    modport slave (
        input  DAT_I, CYC_I, STB_I, ACK_I,
        output ACK_O, DAT_O, WE_O, STB_O, CYC_O, SYM_O
    );

    // Environment side: Synch upstream plus FFT downstream.
    modport master (
        output DAT_I, CYC_I, STB_I, ACK_I,
        input  ACK_O, DAT_O, WE_O, STB_O, CYC_O, SYM_O
    );
endinterface

// File: rtl/cp_remove.sv
// Cyclic-prefix remover: drops the first NCP samples of every NFFT+NCP sample
// OFDM symbol and forwards the NFFT useful samples, tagged with their symbol
// index, through a small elastic FIFO.
module cp_remove #(
    parameter int NFFT    = 256,
    parameter int NCP     = 32,
    parameter int FIFO_AW = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,   // asynchronous, active-low
    cp_remove_if.slave  bus
);
    localparam int SYM_LEN = NFFT + NCP;
    localparam int SMP_W   = $clog2(SYM_LEN);
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int CNT_W   = FIFO_AW + 1;
    localparam int ENT_W   = 32 + 8;

    localparam logic [SMP_W-1:0]   SMP_LAST = SMP_W'(SYM_LEN - 1);
    localparam logic [SMP_W-1:0]   SMP_NCP  = SMP_W'(NCP);
    localparam logic [SMP_W-1:0]   SMP_ONE  = SMP_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    // Sample position within the symbol and symbol index within the frame.
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [7:0]         sym_q, sym_d;

    // FIFO state: storage, pointers and occupancy.
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               cyc_o_q, cyc_o_d;

    logic               empty, full, in_cp, acc, push, pop;
    logic [ENT_W-1:0]   head;

    // Handshake decode: prefix samples are always taken, useful ones need room.
    always_comb begin
        empty = (cnt_q == '0);
        full  = (cnt_q == CNT_FULL);
        in_cp = (smp_q < SMP_NCP);
        acc   = RST_I & bus.CYC_I & bus.STB_I & (in_cp | ~full);
        push  = acc & ~in_cp;
        pop   = ~empty & bus.ACK_I;
    end

    // Sample/symbol counters; dropping CYC_I restarts both for the next frame.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        smp_d = smp_q;
        sym_d = sym_q;
        if (!bus.CYC_I) begin
            smp_d = '0;
            sym_d = '0;
        end else if (acc) begin
            if (smp_q == SMP_LAST) begin
                smp_d = '0;
                sym_d = sym_q + 8'd1;
            end else begin
                smp_d = smp_q + SMP_ONE;
            end
        end
    end

    // FIFO pointer/occupancy update and output-frame flag.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        cyc_o_d = cyc_o_q;
        if (push) begin
            cyc_o_d = 1'b1;
        end else if (empty && !bus.CYC_I) begin
            cyc_o_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
        if (!RST_I) begin
            smp_q    <= '0;
            sym_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            cyc_o_q  <= 1'b0;
        end else begin
            smp_q    <= smp_d;
            sym_q    <= sym_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            cyc_o_q  <= cyc_o_d;
        end
    end

    // FIFO storage write: sample plus the symbol index it belongs to.
    always_ff @(posedge CLK_I) begin
        // NOTE: storage is not reset; occupancy gating makes stale entries invisible.
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.DAT_I, sym_q};
        end
    end

    // Output side presents the FIFO head, forced to zero while empty.
    always_comb begin
        head = empty ? '0 : mem_q[rd_ptr_q];
    end

    assign bus.ACK_O = acc;
    assign bus.STB_O = ~empty;
    assign bus.WE_O  = ~empty;
    assign bus.CYC_O = cyc_o_q;
    assign bus.DAT_O = head[ENT_W-1:8];
    assign bus.SYM_O = head[7:0];
endmodule

// File: tb/tb_cp_remove.sv
// Self-checking bench for cp_remove: a small stripping model pushes expected
// {sample, symbol} entries when a sample is accepted; a monitor pops and
// compares them on every output handshake.
module tb_cp_remove;
    logic clk = 1'b0;
    logic rst_n;

    cp_remove_if bus ();

    cp_remove #(.NFFT(256), .NCP(32), .FIFO_AW(2)) dut (
        .CLK_I (clk),
        .RST_I (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          fails     = 0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_exp;
    int          out_cnt   = 0;
    int          last_sym  = -1;
    int          m_smp     = 0;
    int          m_sym     = 0;
    bit          rand_ack  = 1'b0;

    function automatic logic [31:0] smp_val(input int k);
        smp_val = {16'(-k), 16'(k)};
    endfunction

    // Output monitor: the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.STB_O && bus.ACK_I) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected: got dat=%h sym=%0d, required no output",
                         bus.DAT_O, bus.SYM_O);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.WE_O, bus.DAT_O, bus.SYM_O} !== {1'b1, mon_exp}) begin
                    fails++;
                    $display("FAIL out_data: got we=%b dat=%h sym=%0d, required we=1 dat=%h sym=%0d",
                             bus.WE_O, bus.DAT_O, bus.SYM_O, mon_exp[39:8], mon_exp[7:0]);
                end
            end
            out_cnt++;
            last_sym = int'(bus.SYM_O);
        end
    end

    // Random FFT back-pressure.
    always @(posedge clk) begin
        if (rand_ack) begin
            #1 bus.ACK_I = 1'($urandom_range(0, 1));
        end
    end

    task automatic model_accept(input logic [31:0] d);
        if (m_smp >= 32) exp_q.push_back({d, 8'(m_sym)});
        if (m_smp == 287) begin
            m_smp = 0;
            m_sym = (m_sym + 1) % 256;
        end else begin
            m_smp++;
        end
    endtask

    // Offer one sample until accepted; returns at posedge+1.
    task automatic put(input logic [31:0] d);
        bit done  = 1'b0;
        int tries = 0;
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.DAT_I = d;
        while (!done) begin
            @(negedge clk);
            done = bus.ACK_O;
            @(posedge clk);
            if (done) model_accept(d);
            #1;
            tries++;
            if (!done && tries >= 200) begin
                tests_run++;
                fails++;
                $display("FAIL put_timeout: sample %h not accepted in %0d cycles, required acceptance", d, tries);
                done = 1'b1;
            end
        end
        bus.STB_I = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.STB_I = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_end();
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        @(posedge clk);
        #1;
        m_smp = 0;
        m_sym = 0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || bus.STB_O !== 1'b0) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        tests_run++;
        if (exp_q.size() != 0 || bus.STB_O !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain: pending=%0d stb=%b, required pending=0 stb=0", name, exp_q.size(), bus.STB_O);
        end
    endtask

    // One full symbol; also checks first-output latency and CYC_O rise.
    task automatic run_frame(input int base);
        for (int i = 0; i < 288; i++) begin
            put(smp_val(base + i));
            if (i == 31 || i == 32) begin
                tests_run++;
                if ({bus.STB_O, bus.CYC_O} !== {2{i == 32}}) begin
                    fails++;
                    $display("FAIL first_out_k%0d: stb=%b cyc_o=%b, required stb=%0d cyc_o=%0d",
                             i, bus.STB_O, bus.CYC_O, i == 32, i == 32);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.DAT_I = 32'hDEAD_BEEF;
        bus.ACK_I = 1'b1;
        #12;
        tests_run++;
        if ({bus.ACK_O, bus.STB_O, bus.WE_O, bus.CYC_O, bus.DAT_O, bus.SYM_O} !== 44'd0) begin
            fails++;
            $display("FAIL reset_outputs: ack=%b stb=%b we=%b cyc=%b dat=%h sym=%0d, required all 0",
                     bus.ACK_O, bus.STB_O, bus.WE_O, bus.CYC_O, bus.DAT_O, bus.SYM_O);
        end
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({bus.STB_O, bus.CYC_O} !== 2'b00) begin
            fails++;
            $display("FAIL reset_release: stb=%b cyc=%b, required 0 0", bus.STB_O, bus.CYC_O);
        end
    endtask

    task automatic test_one_frame();
        out_cnt = 0;
        run_frame(0);
        frame_end();
        wait_drain("one_frame");
        idle(2);
        tests_run++;
        if (out_cnt !== 256 || last_sym !== 0 || bus.CYC_O !== 1'b0) begin
            fails++;
            $display("FAIL one_frame_count: outputs=%0d last_sym=%0d cyc_o=%b, required 256 0 0",
                     out_cnt, last_sym, bus.CYC_O);
        end
    endtask

    task automatic test_back_to_back();
        int low = 0;
        out_cnt = 0;
        for (int k = 0; k < 864; k++) begin
            put(smp_val(k));
            if (k >= 32 && bus.STB_O === 1'b0) low++;
        end
        tests_run++;
        if (low !== 64) begin
            fails++;
            $display("FAIL b2b_gap: stb low cycles=%0d, required 64", low);
        end
        frame_end();
        wait_drain("b2b");
        tests_run++;
        if (out_cnt !== 768 || last_sym !== 2) begin
            fails++;
            $display("FAIL b2b_count: outputs=%0d last_sym=%0d, required 768 2", out_cnt, last_sym);
        end
    endtask

    task automatic test_stall();
        int k;
        bit a;
        out_cnt   = 0;
        bus.ACK_I = 1'b1;
        for (k = 0; k < 40; k++) put(smp_val(k));
        idle(1);
        bus.ACK_I = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.CYC_I = 1'b1;
            bus.STB_I = 1'b1;
            bus.DAT_I = smp_val(k);
            @(negedge clk);
            a = bus.ACK_O;
            tests_run++;
            if (a !== (c < 4)) begin
                fails++;
                $display("FAIL stall_ack_c%0d: ack_o=%b, required %0d", c, a, c < 4);
            end
            if (c >= 4) begin
                tests_run++;
                if ({bus.STB_O, bus.DAT_O} !== {1'b1, smp_val(40)}) begin
                    fails++;
                    $display("FAIL stall_frozen_c%0d: stb=%b dat=%h, required stb=1 dat=%h",
                             c, bus.STB_O, bus.DAT_O, smp_val(40));
                end
            end
            @(posedge clk);
            if (a) begin
                model_accept(smp_val(k));
                k++;
            end
            #1;
        end
        bus.STB_I = 1'b0;
        bus.ACK_I = 1'b1;
        for (; k < 288; k++) put(smp_val(k));
        frame_end();
        wait_drain("stall");
        tests_run++;
        if (out_cnt !== 256) begin
            fails++;
            $display("FAIL stall_count: outputs=%0d, required 256", out_cnt);
        end
    endtask

    task automatic test_frame_drop();
        out_cnt = 0;
        for (int k = 0; k < 100; k++) put(smp_val(k));
        frame_end();
        wait_drain("drop1");
        idle(2);
        tests_run++;
        if (out_cnt !== 68 || bus.CYC_O !== 1'b0) begin
            fails++;
            $display("FAIL drop_frame1: outputs=%0d cyc_o=%b, required 68 0", out_cnt, bus.CYC_O);
        end
        out_cnt = 0;
        run_frame(2000);
        frame_end();
        wait_drain("drop2");
        tests_run++;
        if (out_cnt !== 256 || last_sym !== 0) begin
            fails++;
            $display("FAIL drop_frame2: outputs=%0d last_sym=%0d, required 256 0", out_cnt, last_sym);
        end
    endtask

    task automatic test_reset_mid();
        bus.ACK_I = 1'b0;
        for (int k = 0; k < 36; k++) put(smp_val(k));
        tests_run++;
        if ({bus.STB_O, bus.CYC_O} !== 2'b11) begin
            fails++;
            $display("FAIL midrst_fill: stb=%b cyc=%b, required 1 1", bus.STB_O, bus.CYC_O);
        end
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.ACK_O, bus.STB_O, bus.WE_O, bus.CYC_O, bus.DAT_O, bus.SYM_O} !== 44'd0) begin
            fails++;
            $display("FAIL midrst_outputs: ack=%b stb=%b we=%b cyc=%b dat=%h sym=%0d, required all 0",
                     bus.ACK_O, bus.STB_O, bus.WE_O, bus.CYC_O, bus.DAT_O, bus.SYM_O);
        end
        exp_q.delete();
        m_smp     = 0;
        m_sym     = 0;
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        bus.ACK_I = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_cnt = 0;
        run_frame(500);
        frame_end();
        wait_drain("midrst");
        tests_run++;
        if (out_cnt !== 256 || last_sym !== 0) begin
            fails++;
            $display("FAIL midrst_frame: outputs=%0d last_sym=%0d, required 256 0", out_cnt, last_sym);
        end
    endtask

    task automatic test_random();
        out_cnt  = 0;
        rand_ack = 1'b1;
        for (int i = 0; i < 1440; i++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            put(smp_val(7000 + i));
        end
        frame_end();
        rand_ack = 1'b0;
        @(posedge clk);
        #2;
        bus.ACK_I = 1'b1;
        wait_drain("random");
        tests_run++;
        if (out_cnt !== 1280 || last_sym !== 4) begin
            fails++;
            $display("FAIL random_count: outputs=%0d last_sym=%0d, required 1280 4", out_cnt, last_sym);
        end
    endtask

    initial begin
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        bus.DAT_I = '0;
        bus.ACK_I = 1'b1;
        test_reset();
        test_one_frame();
        test_back_to_back();
        test_stall();
        test_frame_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
